// File: rtl/share_pkg.sv
// ============================================================================
// Module : share_pkg
// Brief  : Shared defaults, entry layout and pointer sizing for share_queue.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package share_pkg;

    localparam int c_DEPTH   = 8;
    localparam int c_NONCE_W = 32;
    localparam int c_ID_W    = 8;

    typedef struct packed {
        logic [c_ID_W-1:0]    id;
        logic [c_NONCE_W-1:0] nonce;
    } share_entry_t;

    // One extra MSB distinguishes full from empty when the low bits match.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/share_ram.sv
// ============================================================================
// Module : share_ram
// Brief  : DEPTH x WIDTH register array, one write port, one async read port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module share_ram
    import share_pkg::*;
#(
    parameter int DEPTH = c_DEPTH,
    parameter int WIDTH = c_ID_W + c_NONCE_W
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage carries no reset; validity is tracked by the queue pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/share_queue.sv
// ============================================================================
// Module : share_queue
// Brief  : Captures winning nonces with their work ID into a show-ahead FIFO
//          and keeps result, hit and drop counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module share_queue
    import share_pkg::*;
#(
    parameter int DEPTH   = c_DEPTH,
    parameter int NONCE_W = c_NONCE_W,
    parameter int ID_W    = c_ID_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     res_valid,
    input  logic                     res_hit,
    input  logic [NONCE_W-1:0]       res_nonce,
    input  logic [ID_W-1:0]          work_id,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NONCE_W-1:0]       out_nonce,
    output logic [ID_W-1:0]          out_id,
    output logic [$clog2(DEPTH):0]   level,
    output logic [47:0]              res_count,
    output logic [31:0]              hit_count,
    output logic [15:0]              drop_count
);

    localparam int c_PW = ptr_w(DEPTH);
    localparam int c_AW = c_PW - 1;
    localparam int c_EW = ID_W + NONCE_W;

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [47:0]     r_res_count;
    logic [31:0]     r_hit_count;
    logic [15:0]     r_drop_count;

    logic            w_empty;
    logic            w_full;
    logic            w_push_req;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [c_EW-1:0] w_rd_data;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    assign w_push_req = res_valid & res_hit;
    assign w_pop      = ~w_empty & out_ready & ~flush;
    // A full queue still accepts when the head leaves in the same cycle.
    assign w_push     = w_push_req & ~flush & (~w_full | w_pop);
    assign w_drop     = w_push_req & ~flush & w_full & ~w_pop;

    share_ram #(
        .DEPTH (DEPTH),
        .WIDTH (c_EW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr[c_AW-1:0]),
        .wr_data ({work_id, res_nonce}),
        .rd_addr (r_rd_ptr[c_AW-1:0]),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_count  <= '0;
            r_hit_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (res_valid) begin
                r_res_count <= r_res_count + 48'd1;
            end
            if (w_push_req) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    // Head data is forced to zero while empty so reset clears every output.
    assign out_valid  = ~w_empty;
    assign out_nonce  = w_empty ? '0 : w_rd_data[NONCE_W-1:0];
    assign out_id     = w_empty ? '0 : w_rd_data[c_EW-1:NONCE_W];
    assign level      = r_wr_ptr - r_rd_ptr;
    assign res_count  = r_res_count;
    assign hit_count  = r_hit_count;
    assign drop_count = r_drop_count;

endmodule

`default_nettype wire

// File: doc/share_queue.md
# share_queue

Downstream capture stage for the mining pipeline. Consumes the per-candidate result stream that accompanies each nonce leaving the compare stage (valid, hit flag, nonce) and buffers every winning nonce in a small FIFO, tagged with the work ID it was mined under. Downstream, a reporting consumer drains the FIFO over a valid/ready handshake, so back-to-back golden nonces are no longer overwritten. Also maintains hashrate and loss counters for the probe interface.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..64.
- NONCE_W, 32: nonce width.
- ID_W, 8: work-ID tag width.
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- res_valid  in  1  one result presented this cycle.
- res_hit  in  1  result met target; ignored when res_valid=0.
- res_nonce  in  NONCE_W  nonce of the presented result.
- work_id  in  ID_W  tag of current work; sampled with each push.
- flush  in  1  single-cycle pulse on new work; discards queued shares.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head this cycle.
- out_nonce  out  NONCE_W  head nonce.
- out_id  out  ID_W  head work ID.
- level  out  clog2(DEPTH)+1  current occupancy.
- res_count  out  48  results seen (res_valid cycles), wrapping.
- hit_count  out  32  hits seen (accepted + dropped), wrapping.
- drop_count  out  16  hits lost to full FIFO, saturating at 0xFFFF.

## Operation
- Push request: res_valid & res_hit. Pop: out_valid & out_ready.
- Storage: circular buffer, write/read pointers of clog2(DEPTH)+1 bits; empty when pointers equal, full when MSBs differ and low bits equal. Pointers wrap modulo 2·DEPTH.
- Push with not full: entry {work_id, res_nonce} written at write pointer, level +1.
- Push when full with same-cycle pop: both occur; level unchanged; no drop.
- Push when full, no pop: entry discarded, drop_count +1 (saturating), hit_count still +1.
- Pop with push on non-full: level unchanged, ordering preserved (strict FIFO).
- Pop when empty: impossible (out_valid=0); out_ready ignored.
- flush: at the edge, both pointers reset to 0 (level 0). A same-cycle push is discarded and a same-cycle pop is void; neither counts as a drop. Counters (res/hit) still advance for that cycle's inputs.
- res_count +1 on every res_valid cycle; hit_count +1 on every push request.
- No state machine beyond pointer/counter state; show-ahead output: out_nonce/out_id always reflect the head entry while out_valid=1, undefined-but-stable-is-not-required when out_valid=0 (bench must not check).

## Timing
- Reset (async assert, sync-edge release): pointers 0, out_valid 0, level 0, res_count 0, hit_count 0, drop_count 0.
- Push at edge N into empty FIFO: out_valid=1 and out_nonce valid from after edge N (one-cycle latency).
- Pop at edge N: next entry (or out_valid=0) visible after edge N; one pop per cycle sustained.
- level, counters update at the same edge as the causing event; all outputs registered or driven directly from registers (pointers + storage read), no combinational path from res_* to out_*.
- out_valid and out_ready have no combinational dependency on each other.
- Reset asserted mid-traffic: all state cleared immediately; queued shares lost.

## Structure
- Shared package share_pkg: DEPTH, NONCE_W, ID_W defaults, pointer width function (clog2(DEPTH)+1), entry type {id, nonce}.
- One sub-module: share_ram, DEPTH × (ID_W+NONCE_W) register array, write port + async read port; pointer, flag and counter logic stay in share_queue.

## Test plan
- Reset then single hit nonce 0x0000_1234, work_id 0x05 -> out_valid=1 one cycle later, out_nonce 0x1234, out_id 0x05, level 1; pop with out_ready -> level 0, hit_count 1.
- 10 consecutive hits (nonces 1..10), out_ready=0, DEPTH=8 -> level 8, drop_count 2, hit_count 10; drain yields 1..8 in order.
- Full FIFO, push nonce 0x99 with simultaneous pop -> drop_count unchanged, 0x99 emerges last after 7 more pops.
- 3 entries queued, flush pulse coincident with hit 0x55 -> level 0, out_valid 0 next cycle, 0x55 not stored, drop_count 0, hit_count includes it.
- 1000 res_valid cycles with res_hit on every 100th -> res_count 1000, hit_count 10; res_hit high with res_valid low -> no push, no count.
- drop_count preloaded near saturation via 65540 overflow hits -> holds 0xFFFF; async rst mid-stream -> all outputs 0 without clock edge.
